dqs_eye_track_ctrl: RTL and testbench

Closed-loop read-DQS delay tracking controller for one DDR3 byte lane. It sits directly upstream of the lane's DQS I/O delay block. It consumes that block's eye-monitor EARLY/LATE flags and its delay-line out-of-range flag, and drives the delay-line LOAD/MOVE/DIRECTION and eye-monitor clear/width controls to keep the captured DQS centred. All logic runs on the fabric clock that also clocks the IOD's RX/TX fabric side.

---
 rtl/dqs_eye_track_if.sv | 55 +++++
 rtl/dqs_eye_track_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dqs_eye_track_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dqs_eye_track_if.sv
// ============================================================================
// dqs_eye_track_if: control/status bundle between the DQS tracking controller
// and the byte-lane IOD.                                  Revision 1.0
// ============================================================================
`default_nettype none

interface dqs_eye_track_if;
    logic       train_en;
    logic       eye_monitor_early;
    logic       eye_monitor_late;
    logic       delay_line_out_of_range;
    logic       delay_line_load;
    logic       delay_line_move;
    logic       delay_line_direction;
    logic       eye_monitor_clear_flags;
    logic [2:0] eye_monitor_lane_width;
    logic [7:0] tap_count;
    logic       busy;
    logic       locked;
    logic       error;

    modport master (
        input  train_en,
        input  eye_monitor_early,
        input  eye_monitor_late,
        input  delay_line_out_of_range,
        output delay_line_load,
        output delay_line_move,
        output delay_line_direction,
        output eye_monitor_clear_flags,
        output eye_monitor_lane_width,
        output tap_count,
        output busy,
        output locked,
        output error
    );

    modport slave (
        output train_en,
        output eye_monitor_early,
        output eye_monitor_late,
        output delay_line_out_of_range,
        input  delay_line_load,
        input  delay_line_move,
        input  delay_line_direction,
        input  eye_monitor_clear_flags,
        input  eye_monitor_lane_width,
        input  tap_count,
        input  busy,
        input  locked,
        input  error
    );
endinterface

`default_nettype wire

// File: rtl/dqs_eye_track_ctrl.sv
// ============================================================================
// dqs_eye_track_ctrl: closed-loop read-DQS delay tracking for one DDR3 byte
// lane, driven by the IOD eye-monitor EARLY/LATE flags.   Revision 1.0
// ============================================================================
`default_nettype none

module dqs_eye_track_ctrl #(
    parameter int         INIT_TAP       = 1,
    parameter int         MAX_TAP        = 255,
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         VOTE_THRESHOLD = 3,
    parameter logic [2:0] EM_WIDTH       = 3'b001
) (
    input  wire logic          fab_clk,
    input  wire logic          reset_n,
    dqs_eye_track_if.master    bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_MOVE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic        [7:0] C_INIT_TAP    = 8'(INIT_TAP);
    localparam logic        [7:0] C_MAX_TAP     = 8'(MAX_TAP);
    localparam logic        [7:0] C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic signed [4:0] C_VOTE_POS    = 5'(VOTE_THRESHOLD);
    localparam logic signed [4:0] C_VOTE_NEG    = -C_VOTE_POS;
    localparam logic        [3:0] C_CENTRE_MAX  = 4'(VOTE_THRESHOLD);

    state_t             r_state;
    state_t             w_next;
    logic        [7:0]  r_settle;
    logic signed [4:0]  r_vote;
    logic signed [4:0]  w_vote_nxt;
    logic        [3:0]  r_centre;
    logic        [3:0]  w_centre_nxt;
    logic        [7:0]  r_tap;
    logic               r_load;
    logic               r_move;
    logic               r_dir;
    logic               r_clear;
    logic               r_busy;
    logic               r_locked;
    logic               r_error;
    logic               w_busy_st;
    logic               w_sample_go;
    logic               w_vote_up;
    logic               w_vote_dn;

    assign bus.delay_line_load         = r_load;
    assign bus.delay_line_move         = r_move;
    assign bus.delay_line_direction    = r_dir;
    assign bus.eye_monitor_clear_flags = r_clear;
    assign bus.eye_monitor_lane_width  = EM_WIDTH;
    assign bus.tap_count               = r_tap;
    assign bus.busy                    = r_busy;
    assign bus.locked                  = r_locked;
    assign bus.error                   = r_error;

    assign w_busy_st   = (r_state != ST_IDLE) && (r_state != ST_ERR);
    assign w_sample_go = (r_state == ST_SAMPLE) && bus.train_en
                         && !bus.delay_line_out_of_range;

    // One-sided samples accumulate a net vote; centred samples build lock confidence.
    always_comb begin
        w_vote_nxt   = r_vote;
        w_centre_nxt = r_centre;
        if (bus.eye_monitor_early && !bus.eye_monitor_late) begin
            w_vote_nxt   = (r_vote >= C_VOTE_POS) ? C_VOTE_POS : r_vote + 5'sd1;
            w_centre_nxt = '0;
        end else if (bus.eye_monitor_late && !bus.eye_monitor_early) begin
            w_vote_nxt   = (r_vote <= C_VOTE_NEG) ? C_VOTE_NEG : r_vote - 5'sd1;
            w_centre_nxt = '0;
        end else begin
            w_vote_nxt   = '0;
            w_centre_nxt = (r_centre >= C_CENTRE_MAX) ? C_CENTRE_MAX : r_centre + 4'd1;
        end
    end

    assign w_vote_up = (w_vote_nxt == C_VOTE_POS);
    assign w_vote_dn = (w_vote_nxt == C_VOTE_NEG);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.train_en) w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_CLEAR;
            ST_CLEAR:  w_next = ST_SETTLE;
            ST_SETTLE: if (r_settle == C_SETTLE_LAST) w_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (w_vote_up) begin
                    w_next = (r_tap < C_MAX_TAP) ? ST_MOVE : ST_ERR;
                end else if (w_vote_dn) begin
                    w_next = (r_tap != 8'd0) ? ST_MOVE : ST_ERR;
                end else begin
                    w_next = ST_CLEAR;
                end
            end
            ST_MOVE:   w_next = ST_CLEAR;
            ST_ERR:    w_next = ST_ERR;
            default:   w_next = ST_IDLE;
        endcase
        if (w_busy_st && bus.delay_line_out_of_range) begin
            w_next = ST_ERR;
        end
        if (!bus.train_en) begin
            w_next = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge fab_clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_vote   <= '0;
            r_centre <= '0;
            r_tap    <= C_INIT_TAP;
            r_load   <= 1'b0;
            r_move   <= 1'b0;
            r_dir    <= 1'b0;
            r_clear  <= 1'b0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= (w_next == ST_LOAD);
            r_move  <= (w_next == ST_MOVE);
            r_clear <= (w_next == ST_CLEAR);
            r_busy  <= (w_next != ST_IDLE) && (w_next != ST_ERR);

            if (r_state == ST_CLEAR) begin
                r_settle <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_settle <= r_settle + 8'd1;
            end

            if (w_next == ST_LOAD) begin
                r_tap    <= C_INIT_TAP;
                r_vote   <= '0;
                r_centre <= '0;
                r_locked <= 1'b0;
                r_error  <= 1'b0;
            end else begin
                if (w_next == ST_ERR) begin
                    r_error <= 1'b1;
                end
                if (w_sample_go) begin
                    r_vote   <= w_vote_nxt;
                    r_centre <= w_centre_nxt;
                    if (w_next == ST_MOVE) begin
                        r_locked <= 1'b0;
                        r_dir    <= w_vote_up;
                    end else if (w_centre_nxt == C_CENTRE_MAX) begin
                        r_locked <= 1'b1;
                    end
                end
                // An issued MOVE pulse always moves the IOD, so the tap tracks it even if aborted.
                if (r_state == ST_MOVE) begin
                    r_tap  <= r_dir ? r_tap + 8'd1 : r_tap - 8'd1;
                    r_vote <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dqs_eye_track_ctrl.sv
// ============================================================================
// tb_dqs_eye_track_ctrl: randomized scoreboard bench with an event-scheduled
// reference model plus directed timing checks.            Revision 1.0
// ============================================================================
`default_nettype none

module tb_dqs_eye_track_ctrl;

    localparam int INIT_TAP = 1;
    localparam int MAX_TAP  = 255;
    localparam int S        = 4;
    localparam int VT       = 3;

    typedef struct {
        int         cyc;
        logic       load;
        logic       move;
        logic       dir;
        logic       clear;
        logic       busy;
        logic       locked;
        logic       error;
        logic [7:0] tap;
    } rec_t;

    logic fab_clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    rec_t exp_q[$];

    dqs_eye_track_if bus ();

    dqs_eye_track_ctrl #(
        .INIT_TAP       (INIT_TAP),
        .MAX_TAP        (MAX_TAP),
        .SETTLE_CYCLES  (S),
        .VOTE_THRESHOLD (VT),
        .EM_WIDTH       (3'b001)
    ) dut (
        .fab_clk (fab_clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 fab_clk = ~fab_clk;
    always @(posedge fab_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: schedules the next clear/sample/move by cycle number.
    bit   m_run, m_err, m_locked, m_error, m_dir;
    int   m_tap, m_vote, m_centre, m_t_sample, m_t_clear, m_t_move;
    rec_t m_prev;

    task automatic model_reset();
        m_run = 0; m_err = 0; m_locked = 0; m_error = 0; m_dir = 0;
        m_tap = INIT_TAP; m_vote = 0; m_centre = 0;
        m_t_sample = -1; m_t_clear = -1; m_t_move = -1;
        m_prev = '{cyc: 0, load: 0, move: 0, dir: 0, clear: 0, busy: 0,
                   locked: 0, error: 0, tap: 8'(INIT_TAP)};
    endtask

    task automatic model_cycle(input int n, input bit te, input bit e, input bit l, input bit oor);
        rec_t r;
        bit   up, start;
        start = 0;
        if (m_t_move == n) begin
            m_tap  = m_dir ? m_tap + 1 : m_tap - 1;
            m_vote = 0;
        end
        if (!te) begin
            m_run = 0; m_err = 0;
        end else if (!m_run && !m_err) begin
            start = 1; m_run = 1;
            m_tap = INIT_TAP; m_vote = 0; m_centre = 0; m_locked = 0; m_error = 0;
            m_t_move = -1; m_t_clear = n + 2; m_t_sample = n + 3 + S;
        end else if (m_run && oor) begin
            m_run = 0; m_err = 1; m_error = 1;
        end else if (m_run && n == m_t_sample) begin
            if (e && !l) begin
                m_vote = (m_vote + 1 > VT) ? VT : m_vote + 1; m_centre = 0;
            end else if (l && !e) begin
                m_vote = (m_vote - 1 < -VT) ? -VT : m_vote - 1; m_centre = 0;
            end else begin
                m_vote = 0; m_centre = (m_centre + 1 > VT) ? VT : m_centre + 1;
            end
            if (m_vote == VT || m_vote == -VT) begin
                up = (m_vote > 0);
                if (up ? (m_tap < MAX_TAP) : (m_tap > 0)) begin
                    m_dir = up; m_locked = 0;
                    m_t_move = n + 1; m_t_clear = n + 2; m_t_sample = n + 3 + S;
                end else begin
                    m_run = 0; m_err = 1; m_error = 1;
                end
            end else begin
                if (m_centre == VT) m_locked = 1;
                m_t_clear = n + 1; m_t_sample = n + 2 + S;
            end
        end
        r.cyc    = n + 1;
        r.load   = start;
        r.move   = m_run && (m_t_move == n + 1);
        r.clear  = m_run && (m_t_clear == n + 1);
        r.dir    = m_dir;
        r.busy   = m_run;
        r.locked = m_locked;
        r.error  = m_error;
        r.tap    = 8'(m_tap);
        if (r.load || r.move || r.clear || r.tap != m_prev.tap || r.busy != m_prev.busy
            || r.locked != m_prev.locked || r.error != m_prev.error)
            exp_q.push_back(r);
        m_prev = r;
    endtask

    // Monitor: any pulse or status change on the DUT consumes one expected record.
    initial begin : monitor
        rec_t a, p, e;
        bit   started;
        started = 0;
        forever begin
            @(negedge fab_clk);
            if (mon_en) begin
                a = '{cyc: cyc, load: bus.delay_line_load, move: bus.delay_line_move,
                      dir: bus.delay_line_direction, clear: bus.eye_monitor_clear_flags,
                      busy: bus.busy, locked: bus.locked, error: bus.error, tap: bus.tap_count};
                if (started && (a.load || a.move || a.clear || a.tap != p.tap
                    || a.busy != p.busy || a.locked != p.locked || a.error != p.error)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected at cycle %0d: ld=%0b mv=%0b clr=%0b tap=%0d busy=%0b lk=%0b err=%0b, none expected",
                                 cyc, a.load, a.move, a.clear, a.tap, a.busy, a.locked, a.error);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != a.cyc || e.load != a.load || e.move != a.move
                            || e.clear != a.clear || (e.move && e.dir != a.dir)
                            || e.tap != a.tap || e.busy != a.busy || e.locked != a.locked
                            || e.error != a.error || bus.eye_monitor_lane_width != 3'b001) begin
                            failures++;
                            $display("FAIL sb_event got cyc=%0d ld=%0b mv=%0b dir=%0b clr=%0b tap=%0d busy=%0b lk=%0b err=%0b w=%0d expected cyc=%0d ld=%0b mv=%0b dir=%0b clr=%0b tap=%0d busy=%0b lk=%0b err=%0b w=1",
                                     a.cyc, a.load, a.move, a.dir, a.clear, a.tap, a.busy, a.locked,
                                     a.error, bus.eye_monitor_lane_width, e.cyc, e.load, e.move,
                                     e.dir, e.clear, e.tap, e.busy, e.locked, e.error);
                        end
                    end
                end
                p = a;
                started = 1;
            end
        end
    end

    task automatic step(input bit te, input bit e, input bit l, input bit oor);
        bus.train_en                = te;
        bus.eye_monitor_early       = e;
        bus.eye_monitor_late        = l;
        bus.delay_line_out_of_range = oor;
        model_cycle(cyc, te, e, l, oor);
        @(posedge fab_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'(($urandom >> 3) & 1), 1'(($urandom >> 5) & 1), 1'b0);
    endtask

    logic h_load[64], h_move[64], h_dir[64], h_clear[64], h_busy[64], h_locked[64], h_error[64];
    int   h_tap[64];

    // Drives a held flag pattern; cycle k is relative to the TRAIN_EN rise at k=0.
    task automatic drive_seq(input bit e, input bit l, input int base, input int n, input int oor_at);
        for (int k = base; k < base + n; k++) begin
            step(1'b1, e, l, (k == oor_at));
            h_load[k+1]   = bus.delay_line_load;
            h_move[k+1]   = bus.delay_line_move;
            h_dir[k+1]    = bus.delay_line_direction;
            h_clear[k+1]  = bus.eye_monitor_clear_flags;
            h_busy[k+1]   = bus.busy;
            h_locked[k+1] = bus.locked;
            h_error[k+1]  = bus.error;
            h_tap[k+1]    = int'(bus.tap_count);
        end
    endtask

    initial begin : stimulus
        int moves;
        bus.train_en = 0; bus.eye_monitor_early = 0; bus.eye_monitor_late = 0;
        bus.delay_line_out_of_range = 0;
        reset_n = 0;
        repeat (2) @(posedge fab_clk);
        #1;
        chk("rst_load",  int'(bus.delay_line_load), 0);
        chk("rst_move",  int'(bus.delay_line_move), 0);
        chk("rst_dir",   int'(bus.delay_line_direction), 0);
        chk("rst_clear", int'(bus.eye_monitor_clear_flags), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_lock",  int'(bus.locked), 0);
        chk("rst_err",   int'(bus.error), 0);
        chk("rst_tap",   int'(bus.tap_count), INIT_TAP);
        chk("rst_width", int'(bus.eye_monitor_lane_width), 1);
        reset_n = 1;
        model_reset();
        mon_en = 1;
        idle(3);

        // EARLY held: three votes then an increment.
        drive_seq(1, 0, 0, 21, -1);
        chk("early_load_c1",  int'(h_load[1]), 1);
        chk("early_clear_c2", int'(h_clear[2]), 1);
        chk("early_clear_c8", int'(h_clear[8]), 1);
        chk("early_clear_c14", int'(h_clear[14]), 1);
        chk("early_move_c19", int'(h_move[19]), 0);
        chk("early_move_c20", int'(h_move[20]), 1);
        chk("early_dir_c20",  int'(h_dir[20]), 1);
        chk("early_tap_c20",  h_tap[20], 1);
        chk("early_tap_c21",  h_tap[21], 2);
        idle(2);

        // LATE held from tap 1: decrement to 0, then limit error.
        drive_seq(0, 1, 0, 39, -1);
        moves = 0;
        for (int k = 21; k <= 39; k++) moves += int'(h_move[k]);
        chk("late_move_c20", int'(h_move[20]), 1);
        chk("late_dir_c20",  int'(h_dir[20]), 0);
        chk("late_tap_c21",  h_tap[21], 0);
        chk("late_err_c38",  int'(h_error[38]), 0);
        chk("late_err_c39",  int'(h_error[39]), 1);
        chk("late_busy_c39", int'(h_busy[39]), 0);
        chk("late_no_move",  moves, 0);
        idle(2);

        // Centred samples lock; subsequent EARLY votes unlock with the move.
        drive_seq(1, 1, 0, 21, -1);
        drive_seq(1, 0, 21, 17, -1);
        chk("lock_c19",      int'(h_locked[19]), 0);
        chk("lock_c20",      int'(h_locked[20]), 1);
        chk("lock_nomove20", int'(h_move[20]), 0);
        chk("lock_c37",      int'(h_locked[37]), 1);
        chk("unlock_c38",    int'(h_locked[38]), 0);
        chk("unlock_move38", int'(h_move[38]), 1);
        idle(2);

        // Out-of-range mid-settle, then recovery through LOAD.
        drive_seq(1, 1, 0, 8, 5);
        chk("oor_busy_c5", int'(h_busy[5]), 1);
        chk("oor_err_c6",  int'(h_error[6]), 1);
        chk("oor_busy_c6", int'(h_busy[6]), 0);
        idle(1);
        drive_seq(1, 1, 0, 2, -1);
        chk("reload_load_c1", int'(h_load[1]), 1);
        chk("reload_err_c1",  int'(h_error[1]), 0);
        chk("reload_tap_c1",  h_tap[1], INIT_TAP);
        idle(2);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 30; ep++) begin
            int mode, len;
            bit e, l;
            idle($urandom_range(1, 5));
            mode = $urandom_range(0, 3);
            len  = $urandom_range(20, 160);
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0: begin e = ($urandom_range(0, 9) != 0); l = ($urandom_range(0, 9) == 0); end
                    1: begin e = ($urandom_range(0, 9) == 0); l = ($urandom_range(0, 9) != 0); end
                    2: begin e = 1'($urandom & 1); l = e; end
                    default: begin e = 1'($urandom & 1); l = 1'(($urandom >> 1) & 1); end
                endcase
                step(1'b1, e, l, ($urandom_range(0, 299) == 0));
            end
        end
        idle(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
